// File: rtl/delay_ram_sched.sv
// Pass scheduler for the polynomial delay line.
// Each pass accepts one N-coefficient polynomial from upstream into the current
// ring slot. When the ring is primed, the same pass also streams out the
// polynomial written LENGTH+1 passes earlier. A one-cycle shift pulse rotates
// the ring once both sides have finished the pass.
module delay_ram_sched #(
   parameter int unsigned N      = 512,
   parameter int unsigned AW     = 9,
   parameter int unsigned LENGTH = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [15:0]   in_data,
   output logic          in_ready,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [15:0]   out_data,
   output logic          primed,
   output logic          shift,
   output logic          we_in,
   output logic [AW-1:0] addr_in,
   output logic [15:0]   di_in,
   output logic [AW-1:0] addr_out,
   input  logic [15:0]   do_out
);

   localparam int unsigned   FW       = $clog2(LENGTH + 2);
   localparam logic [FW-1:0] FILL_MAX = FW'(LENGTH + 1);
   localparam logic [AW-1:0] LAST     = AW'(N - 1);

   typedef enum logic {
      RUN   = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_q;
   logic [AW-1:0] wcnt_q;
   logic [AW-1:0] rcnt_q;
   logic          wr_done_q;
   logic          rd_done_q;
   logic [FW-1:0] fill_q;
   logic [FW-1:0] fill_d;
   logic          out_valid_q;
   logic          rd_issue;

   // Handshakes and the saturating fill count taken on leaving SHIFT
   always_comb begin
      in_ready = (state_q == RUN) && !wr_done_q;
      we_in    = in_valid && in_ready;
      rd_issue = (state_q == RUN) && primed && !rd_done_q && out_ready;
      fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
   end

   assign primed    = (fill_q == FILL_MAX);
   assign shift     = (state_q == SHIFT);
   assign out_valid = out_valid_q;
   assign out_data  = do_out;
   assign addr_in   = wcnt_q;
   assign di_in     = in_data;
   assign addr_out  = rcnt_q;

   // Pass FSM: counters advance in RUN, SHIFT rewinds them for the next pass.
   // Pass end is detected from the registered done flags, so the final read's
   // data is returned before the ring rotates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         wr_done_q   <= 1'b0;
         rd_done_q   <= 1'b1;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= rd_issue;
         unique case (state_q)
            RUN: begin
               if (we_in) begin
                  if (wcnt_q == LAST) wr_done_q <= 1'b1;
                  else                wcnt_q    <= wcnt_q + AW'(1);
               end
               if (rd_issue) begin
                  if (rcnt_q == LAST) rd_done_q <= 1'b1;
                  else                rcnt_q    <= rcnt_q + AW'(1);
               end
               if (wr_done_q && rd_done_q) state_q <= SHIFT;
            end
            SHIFT: begin
               state_q   <= RUN;
               wcnt_q    <= '0;
               rcnt_q    <= '0;
               wr_done_q <= 1'b0;
               rd_done_q <= (fill_d != FILL_MAX);
               fill_q    <= fill_d;
            end
            default: state_q <= RUN;
         endcase
      end
   end

endmodule
